// File: rtl/cla_pkg.sv
// Shared definitions for the lookahead-adder accumulation stages.
//
// Contents:
//   state_t      - block FSM states (ACCUM, DONE)
//   CLA_IN_W     - default width of the adder stage's sum (5)
//   CLA_SEXT_W   - working width of sext_to_acc (accumulators must be narrower)
//   sext_to_acc  - sign-extends a right-aligned value whose sign bit is at 'msb'
package cla_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int CLA_IN_W   = 5;
    localparam int CLA_SEXT_W = 32;

    // Bits above 'msb' are replaced by copies of bit 'msb'. Callers slice
    // the low ACC_W bits of the result.
    function automatic logic [CLA_SEXT_W-1:0] sext_to_acc(
        input logic [CLA_SEXT_W-1:0] v,
        input logic [4:0]            msb
    );
        logic [CLA_SEXT_W-1:0] r;
        r = v;
        for (int i = 0; i < CLA_SEXT_W; i++) begin
            if (5'(i) > msb) begin
                r[i] = v[msb];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_sum_accumulator_if.sv
// Stream bundle between the adder stage, the accumulator and its consumer.
//
// Signals:
//   clear     - synchronous abort of the partial block
//   in_valid / in_ready / in_sum     - input sum stream (IN_W bits, signed)
//   out_valid / out_ready / out_acc  - block total stream (ACC_W bits, signed)
//   out_ovf   - overflow/saturation flag for the total on out_acc
// Modports:
//   slave  - the accumulator
//   master - the environment driving sums and consuming totals
interface cla_sum_accumulator_if
    import cla_pkg::*;
#(
    parameter int IN_W  = CLA_IN_W,
    parameter int ACC_W = 12
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport slave (
        input  clear, in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );

    modport master (
        output clear, in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/cla_acc_add_sat.sv
// Combinational ACC_W-bit signed adder with overflow detect.
//
// Ports:
//   a, b  - ACC_W-bit two's-complement operands
//   sum   - wrapped result, or clamped result when CLA_SUM_ACC_SAT_EN is defined
//   ovf   - true result lies outside the ACC_W signed range
//
// Build option: CLA_SUM_ACC_SAT_EN selects clamping instead of wrap-around.
module cla_acc_add_sat #(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    // One guard bit: the top two bits disagree exactly when the ACC_W
    // result is out of range, and the guard bit is the true sign.
    logic [ACC_W:0] full;

    assign full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    assign ovf  = full[ACC_W] ^ full[ACC_W-1];

`ifdef CLA_SUM_ACC_SAT_EN
    localparam logic [ACC_W-1:0] MAX_VAL = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};

    assign sum = ovf ? (full[ACC_W] ? MIN_VAL : MAX_VAL) : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/cla_sum_accumulator.sv
// Running-sum stage behind the 4-bit lookahead adder: accumulates N_SAMPLES
// signed sums per block and presents each block total with a sticky
// overflow flag.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - cla_sum_accumulator_if.slave (clear, input stream, output stream)
//
// Parameters: IN_W (input width), ACC_W (accumulator width, IN_W <= ACC_W < 32),
//             N_SAMPLES (1..255 sums per block).
// Build option: CLA_SUM_ACC_SAT_EN makes the accumulator saturate instead of wrap.
module cla_sum_accumulator
    import cla_pkg::*;
#(
    parameter int IN_W      = CLA_IN_W,
    parameter int ACC_W     = 12,
    parameter int N_SAMPLES = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    cla_sum_accumulator_if.slave   bus
);
    localparam logic [7:0] CNT_LAST = 8'(N_SAMPLES - 1);

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [7:0]       cnt_reg;
    logic             ovf_reg;
    logic [ACC_W-1:0] out_acc_reg;
    logic             out_ovf_reg;
    logic             out_valid_reg;

    logic             in_ready;
    logic             in_hs;
    logic             out_hs;

    // in_ready follows out_ready while a total is held so a new block can
    // start in the same cycle the old total leaves.
    assign in_ready = ~bus.clear & (~out_valid_reg | bus.out_ready);
    assign in_hs    = bus.in_valid & in_ready;
    assign out_hs   = out_valid_reg & bus.out_ready;

    // Sign extension of the incoming sum.
    logic [CLA_SEXT_W-1:0]       ext_full;
    logic [ACC_W-1:0]            ext_sum;
    logic [CLA_SEXT_W-ACC_W-1:0] unused_ext_hi;

    assign ext_full      = sext_to_acc({{(CLA_SEXT_W-IN_W){1'b0}}, bus.in_sum}, 5'(IN_W - 1));
    assign ext_sum       = ext_full[ACC_W-1:0];
    assign unused_ext_hi = ext_full[CLA_SEXT_W-1:ACC_W];

    // A sample accepted in DONE is the first of a fresh block, so the
    // running state it builds on is zero rather than the finished block.
    logic [ACC_W-1:0] acc_base;
    logic [7:0]       cnt_base;
    logic             ovf_base;
    logic [7:0]       cnt_next;
    logic             last_sample;

    assign acc_base    = (state_reg == DONE) ? '0   : acc_reg;
    assign cnt_base    = (state_reg == DONE) ? 8'd0 : cnt_reg;
    assign ovf_base    = (state_reg == DONE) ? 1'b0 : ovf_reg;
    assign cnt_next    = cnt_base + 8'd1;
    assign last_sample = (cnt_base == CNT_LAST);

    logic [ACC_W-1:0] step_sum;
    logic             step_ovf;

    cla_acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc_base),
        .b   (ext_sum),
        .sum (step_sum),
        .ovf (step_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= 8'd0;
            ovf_reg       <= 1'b0;
            out_acc_reg   <= '0;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (bus.clear) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= 8'd0;
            ovf_reg       <= 1'b0;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (in_hs) begin
            // In DONE an input handshake implies the output handshake.
            acc_reg <= step_sum;
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_base | step_ovf;
            if (last_sample) begin
                out_acc_reg   <= step_sum;
                out_ovf_reg   <= ovf_base | step_ovf;
                out_valid_reg <= 1'b1;
                state_reg     <= DONE;
            end else begin
                out_valid_reg <= 1'b0;
                state_reg     <= ACCUM;
            end
        end else if (out_hs) begin
            acc_reg       <= '0;
            cnt_reg       <= 8'd0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            state_reg     <= ACCUM;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_acc   = out_acc_reg;
    assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_cla_sum_accumulator.sv
module tb_cla_sum_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_sum_accumulator_if #(.IN_W(5), .ACC_W(12)) bus ();
    cla_sum_accumulator_if #(.IN_W(5), .ACC_W(6))  bus6 ();

    cla_sum_accumulator #(.IN_W(5), .ACC_W(12), .N_SAMPLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cla_sum_accumulator #(.IN_W(5), .ACC_W(6), .N_SAMPLES(8)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: got %0h", name, got);
        end else begin
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Drive n samples of value s back to back, then drop in_valid at the
    // following negedge (outputs of the last handshake are visible there).
    task automatic feed(input int n, input logic [4:0] s);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sum   = s;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    typedef struct {
        string           name;
        logic [7:0][4:0] sums;
        logic [11:0]     acc;
        logic            ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"plus3_x8",   {8{5'd3}}, 12'd24, 1'b0};
        tbl[1] = '{"alt_m16_p15", {4{5'd15, 5'b10000}}, 12'hFFC, 1'b0};
        tbl[2] = '{"plus1_x8",   {8{5'd1}}, 12'd8, 1'b0};
        tbl[3] = '{"m16_x8",     {8{5'b10000}}, 12'hF80, 1'b0};
        tbl[4] = '{"mixed",      {5'h1F, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, 12'h01B, 1'b0};
        tbl[5] = '{"zeros",      {8{5'd0}}, 12'd0, 1'b0};

        bus.clear = 0; bus.in_valid = 0; bus.in_sum = 0; bus.out_ready = 0;
        bus6.clear = 0; bus6.in_valid = 0; bus6.in_sum = 0; bus6.out_ready = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_acc",   32'(bus.out_acc), 32'd0);
        check("rst_out_ovf",   32'(bus.out_ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Table-driven blocks with out_ready held high.
        bus.out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (i == 7) check({tbl[v].name, "_valid_before"}, 32'(bus.out_valid), 32'd0);
                bus.in_valid = 1'b1;
                bus.in_sum   = tbl[v].sums[i];
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            check({tbl[v].name, "_valid"}, 32'(bus.out_valid), 32'd1);
            check({tbl[v].name, "_acc"},   32'(bus.out_acc), 32'(tbl[v].acc));
            check({tbl[v].name, "_ovf"},   32'(bus.out_ovf), 32'(tbl[v].ovf));
            @(negedge clk);
            check({tbl[v].name, "_drained"}, 32'(bus.out_valid), 32'd0);
        end

        // Backpressure, then a back-to-back start carrying +2.
        bus.out_ready = 1'b0;
        feed(8, 5'd1);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sum   = 5'd2;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("bp_acc_stable",   32'(bus.out_acc), 32'd8);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
        feed(6, 5'd1);
        check("b2b_not_done_early", 32'(bus.out_valid), 32'd0);
        feed(1, 5'd1);
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_acc",   32'(bus.out_acc), 32'd9);
        @(negedge clk);

        // Clear after four samples discards them.
        feed(4, 5'd5);
        bus.clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sum = 5'd7;
        #1;
        check("clr_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        feed(7, 5'd1);
        check("clr_not_done_early", 32'(bus.out_valid), 32'd0);
        feed(1, 5'd1);
        check("clr_valid", 32'(bus.out_valid), 32'd1);
        check("clr_acc",   32'(bus.out_acc), 32'd8);
        @(negedge clk);

        // Clear drops a held total.
        bus.out_ready = 1'b0;
        feed(8, 5'd1);
        check("clrhold_valid", 32'(bus.out_valid), 32'd1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clrhold_dropped", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;

        // Narrow accumulator overflow: 8 x +15 into 6 bits.
        bus6.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus6.in_valid = 1'b1;
            bus6.in_sum   = 5'd15;
        end
        @(negedge clk);
        bus6.in_valid = 1'b0;
        check("w6_valid", 32'(bus6.out_valid), 32'd1);
`ifdef CLA_SUM_ACC_SAT_EN
        check("w6_acc", 32'(bus6.out_acc), 32'd31);
`else
        check("w6_acc", 32'(bus6.out_acc), 32'h38);
`endif
        check("w6_ovf", 32'(bus6.out_ovf), 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-block (out_acc still holds the old total 8).
        feed(3, 5'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mid_acc",   32'(bus.out_acc), 32'd0);
        check("arst_mid_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while a total is held.
        bus.out_ready = 1'b0;
        feed(8, 5'd3);
        check("arst_hold_valid_pre", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hold_valid", 32'(bus.out_valid), 32'd0);
        check("arst_hold_acc",   32'(bus.out_acc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        feed(7, 5'd1);
        check("arst_fresh_not_early", 32'(bus.out_valid), 32'd0);
        feed(1, 5'd1);
        check("arst_fresh_acc", 32'(bus.out_acc), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
